// File: rtl/vldp_stream_ctrl.sv
// rtl/vldp_stream_ctrl.sv - decoder stream controller: reset sequencing, play/pause/stop FSM, word packer
module vldp_stream_ctrl #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 64,
    parameter int RST_CYCLES = 16,
    parameter int CNT_W      = 32
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             host_rst_req,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             dec_rst_n,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stream_dat_count
);

    localparam int K    = OUT_W / IN_W;
    localparam int WC_W = (K > 2) ? $clog2(K) : 1;
    localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [WC_W-1:0] LAST_WORD = WC_W'(K - 1);
    localparam logic [RC_W-1:0] RC_LAST   = RC_W'(RST_CYCLES - 1);

    localparam logic [1:0] CMD_PLAY  = 2'b01;
    localparam logic [1:0] CMD_PAUSE = 2'b10;
    localparam logic [1:0] CMD_STOP  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RESETTING = 2'd1,
        S_PLAY      = 2'd2,
        S_PAUSE     = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [RC_W-1:0]        rc_q, rc_d;
    logic                   host_rst_q;
    logic                   rst_edge;
    logic                   clear_all;
    logic                   accept;
    logic [WC_W-1:0]        wcnt_q;
    logic [OUT_W-IN_W-1:0]  acc_q;
    logic [OUT_W-1:0]       packed_word;

    assign rst_edge    = host_rst_req && !host_rst_q;
    assign state       = state_q;
    assign dec_rst_n   = (state_q != S_RESETTING);
    assign packed_word = {acc_q, in_data};

    // The last slot may only fill if the output register is free or draining this cycle.
    assign in_ready = (state_q == S_PLAY) &&
                      ((wcnt_q != LAST_WORD) || !out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            rc_q       <= '0;
            host_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rc_q       <= rc_d;
            host_rst_q <= host_rst_req;
        end
    end

    always_comb begin
        state_d   = state_q;
        rc_d      = rc_q;
        clear_all = 1'b0;
        if (rst_edge) begin
            state_d   = S_RESETTING;
            rc_d      = '0;
            clear_all = 1'b1;
        end else begin
            case (state_q)
                S_RESETTING: begin
                    if (rc_q == RC_LAST) state_d = S_IDLE;
                    else                 rc_d    = rc_q + RC_W'(1);
                end
                S_IDLE: begin
                    if (cmd_valid && cmd == CMD_PLAY) state_d = S_PLAY;
                end
                S_PLAY: begin
                    if (cmd_valid && cmd == CMD_PAUSE) begin
                        state_d = S_PAUSE;
                    end else if (cmd_valid && cmd == CMD_STOP) begin
                        state_d   = S_IDLE;
                        clear_all = 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (cmd_valid && cmd == CMD_PLAY) begin
                        state_d = S_PLAY;
                    end else if (cmd_valid && cmd == CMD_STOP) begin
                        state_d   = S_IDLE;
                        clear_all = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // A word is shifted into the accumulator until the K-th arrives, which completes out_data.
    always_ff @(posedge sys_clk) begin
        if (!rst) begin
            wcnt_q           <= '0;
            acc_q            <= '0;
            out_valid        <= 1'b0;
            out_data         <= '0;
            stream_dat_count <= '0;
        end else if (clear_all) begin
            wcnt_q           <= '0;
            out_valid        <= 1'b0;
            stream_dat_count <= '0;
        end else begin
            if (out_valid && out_ready) out_valid <= 1'b0;
            if (accept) begin
                stream_dat_count <= stream_dat_count + CNT_W'(1);
                if (wcnt_q == LAST_WORD) begin
                    out_data  <= packed_word;
                    out_valid <= 1'b1;
                    wcnt_q    <= '0;
                end else begin
                    acc_q  <= packed_word[OUT_W-IN_W-1:0];
                    wcnt_q <= wcnt_q + WC_W'(1);
                end
            end
        end
    end

endmodule
